chan_fanout_dispatch: RTL and testbench

Parametrised successor to the PID instruction dispatcher. Sits between the ADC front end and the PID pipeline. Buffers tagged ADC samples in a configurable-depth FIFO and fans each sample out, one instruction per cycle, to every enabled PID channel routed to its source. The output is stalled by a downstream ready, with no bubbles between words.

---
 rtl/chan_fanout_dispatch_pkg.sv | 6 +
 rtl/chan_fanout_dispatch_fifo.sv | 41 ++++
 rtl/chan_fanout_dispatch.sv | 96 +++++++++
 tb/tb_chan_fanout_dispatch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/chan_fanout_dispatch_pkg.sv
// ep_map: config bus address map for the channel fan-out dispatcher
package ep_map;
  localparam logic [15:0] CHAN_SRC_SEL_ADDR = 16'h0010;
  localparam logic [15:0] CHAN_EN_ADDR      = 16'h0011;
  localparam logic [15:0] STAT_CLR_ADDR     = 16'h0020;
endpackage

// File: rtl/chan_fanout_dispatch_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO, dout shows the head while !empty
// ports: clk_in/rst_in (async high), push/din, pop/dout, registered full, empty
module sync_fifo_fwft #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  // a push while full still lands when the same cycle frees a slot
  assign do_push = push & (~full | do_pop);
  assign cnt_nx = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt_nx;
      full <= cnt_nx == (AW+1)'(DEPTH);
    end
  always_ff @(posedge clk_in)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/chan_fanout_dispatch.sv
// chan_fanout_dispatch: buffers tagged ADC samples and fans each out to every routed, enabled PID channel
// ports: clk_in/rst_in (async high); dv_in/src_in/data_in sample in; wr_* config bus;
//        rdy_in downstream ready; dv_out/chan_out/data_out instruction; full_out, sticky ovf_out
module chan_fanout_dispatch
  import ep_map::*;
#(
  parameter int W_SRC = 5,
  parameter int W_DATA = 18,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter int W_CHAN = 5,
  parameter int N_CHAN = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NULL_SRC = 9
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_SRC-1:0]     src_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  input  logic                 rdy_in,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  output logic                 full_out,
  output logic                 ovf_out
);
  logic [W_SRC+W_DATA-1:0] f_dout;
  logic f_empty, pop, accept, h_v;
  logic [W_SRC-1:0] head_src;
  logic [W_SRC-1:0] src_sel [N_CHAN];
  logic [N_CHAN-1:0] en, pend, pend_new, issued;
  logic [W_DATA-1:0] h_data;
  logic unused_wr_data;
  function automatic logic [W_CHAN-1:0] lsb_idx(input logic [N_CHAN-1:0] v);
    lsb_idx = '0;
    for (int i = N_CHAN - 1; i >= 0; i--)
      if (v[i]) lsb_idx = W_CHAN'(i);
  endfunction
  sync_fifo_fwft #(.WIDTH(W_SRC + W_DATA), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(dv_in),
    .din({src_in, data_in}),
    .pop(pop),
    .dout(f_dout),
    .full(full_out),
    .empty(f_empty)
  );
  assign unused_wr_data = ^wr_data;
  assign head_src = f_dout[W_SRC+W_DATA-1:W_DATA];
  assign dv_out = h_v & |pend;
  assign chan_out = lsb_idx(pend);
  assign data_out = h_data;
  assign accept = dv_out & rdy_in;
  // refill the holding register when idle, when the held word routes nowhere,
  // or on the accept that retires its last channel, so issues run back to back
  assign pop = ~f_empty & (~h_v | ~|pend | (accept & ~|(pend & ~issued)));
  always_comb begin
    issued = '0;
    pend_new = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      issued[i] = accept & (chan_out == W_CHAN'(i));
      pend_new[i] = en[i] & (src_sel[i] == head_src) & (head_src != W_SRC'(NULL_SRC));
    end
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      h_v <= 1'b0;
      h_data <= '0;
      pend <= '0;
      en <= '0;
      ovf_out <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) src_sel[i] <= W_SRC'(NULL_SRC);
    end else begin
      if (pop) begin
        h_v <= 1'b1;
        h_data <= f_dout[W_DATA-1:0];
        pend <= pend_new;
      end else begin
        pend <= pend & ~issued;
      end
      if (dv_in & full_out & ~pop) ovf_out <= 1'b1;
      else if (wr_en & (wr_addr == W_WR_ADDR'(STAT_CLR_ADDR))) ovf_out <= 1'b0;
      for (int i = 0; i < N_CHAN; i++)
        if (wr_en & (wr_chan == W_WR_CHAN'(i))) begin
          if (wr_addr == W_WR_ADDR'(CHAN_SRC_SEL_ADDR)) src_sel[i] <= wr_data[W_SRC-1:0];
          if (wr_addr == W_WR_ADDR'(CHAN_EN_ADDR)) en[i] <= wr_data[0];
        end
    end
endmodule

// File: tb/tb_chan_fanout_dispatch.sv
// tb_chan_fanout_dispatch: scoreboard bench for chan_fanout_dispatch
module tb_chan_fanout_dispatch;
  import ep_map::*;
  logic clk_in = 1'b0, rst_in = 1'b1, dv_in = 1'b0, wr_en = 1'b0, rdy_in = 1'b0;
  logic [4:0] src_in = '0;
  logic [17:0] data_in = '0;
  logic [15:0] wr_addr = '0, wr_chan = '0;
  logic [47:0] wr_data = '0;
  logic dv_out, full_out, ovf_out;
  logic [4:0] chan_out;
  logic [17:0] data_out;
  int n_tests = 0, n_fail = 0;
  logic [22:0] q[$];
  logic [22:0] sb_e;
  logic [4:0] src_m [8];
  logic en_m [8];
  always #5 clk_in = ~clk_in;
  chan_fanout_dispatch #(
    .W_SRC(5), .W_DATA(18), .W_WR_ADDR(16), .W_WR_CHAN(16), .W_WR_DATA(48),
    .W_CHAN(5), .N_CHAN(8), .FIFO_DEPTH(16), .NULL_SRC(9)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .dv_in(dv_in), .src_in(src_in), .data_in(data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data), .rdy_in(rdy_in),
    .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out), .full_out(full_out), .ovf_out(ovf_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      src_m[i] = 5'd9;
      en_m[i] = 1'b0;
    end
    q.delete();
  endtask
  task automatic cfg(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_chan = c;
    wr_data = d;
    if (c < 16'd8) begin
      if (a == CHAN_SRC_SEL_ADDR) src_m[c[2:0]] = d[4:0];
      if (a == CHAN_EN_ADDR) en_m[c[2:0]] = d[0];
    end
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask
  task automatic push(input logic [4:0] s, input logic [17:0] d, input bit exp_ok);
    dv_in = 1'b1;
    src_in = s;
    data_in = d;
    if (exp_ok)
      for (int i = 0; i < 8; i++)
        if (en_m[i] && src_m[i] == s && s != 5'd9) q.push_back({i[4:0], d});
    @(negedge clk_in);
    dv_in = 1'b0;
  endtask
  task automatic drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    @(negedge clk_in);
    chk(tag, q.size(), 0);
    chk({tag, "_idle"}, dv_out, 0);
  endtask
  always @(negedge clk_in) begin
    #1;
    if (!rst_in && dv_out && rdy_in) begin
      if (q.size() == 0) chk("unexpected_issue", 1, 0);
      else begin
        sb_e = q.pop_front();
        chk("sb_chan", chan_out, sb_e[22:18]);
        chk("sb_data", data_out, sb_e[17:0]);
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk_in);
    chk("rst_dv", dv_out, 0);
    chk("rst_chan", chan_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_full", full_out, 0);
    chk("rst_ovf", ovf_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    cfg(CHAN_SRC_SEL_ADDR, 0, 2);
    cfg(CHAN_SRC_SEL_ADDR, 3, 2);
    cfg(CHAN_SRC_SEL_ADDR, 7, 2);
    cfg(CHAN_SRC_SEL_ADDR, 40, 2);
    cfg(CHAN_EN_ADDR, 0, 1);
    cfg(CHAN_EN_ADDR, 3, 1);
    cfg(CHAN_EN_ADDR, 7, 1);
    cfg(CHAN_EN_ADDR, 8, 1);
    // fan-out with ready held high
    rdy_in = 1'b1;
    push(5'd2, 18'h1ABCD, 1);
    chk("t1_c1_dv", dv_out, 0);
    @(negedge clk_in);
    chk("t1_c2_dv", dv_out, 1);
    chk("t1_c2_chan", chan_out, 0);
    chk("t1_c2_data", data_out, 18'h1ABCD);
    @(negedge clk_in);
    chk("t1_c3_chan", chan_out, 3);
    @(negedge clk_in);
    chk("t1_c4_chan", chan_out, 7);
    chk("t1_c4_data", data_out, 18'h1ABCD);
    @(negedge clk_in);
    chk("t1_c5_dv", dv_out, 0);
    // ready low for 5 cycles from cycle 3
    push(5'd2, 18'h0BEEF, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    rdy_in = 1'b0;
    chk("t2_c3_chan", chan_out, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("t2_hold_dv", dv_out, 1);
      chk("t2_hold_chan", chan_out, 3);
      chk("t2_hold_data", data_out, 18'h0BEEF);
    end
    @(negedge clk_in);
    rdy_in = 1'b1;
    chk("t2_rel_chan", chan_out, 3);
    @(negedge clk_in);
    chk("t2_last_chan", chan_out, 7);
    @(negedge clk_in);
    chk("t2_done_dv", dv_out, 0);
    // unrouted word costs one idle cycle
    push(5'd4, 18'h11111, 1);
    push(5'd2, 18'h22222, 1);
    chk("t3_c2_dv", dv_out, 0);
    @(negedge clk_in);
    chk("t3_c3_dv", dv_out, 1);
    chk("t3_c3_chan", chan_out, 0);
    chk("t3_c3_data", data_out, 18'h22222);
    drain("t3_drain");
    // fill: first word parks in the holding register, then 16 fill the FIFO
    rdy_in = 1'b0;
    push(5'd2, 18'h00000, 1);
    for (int k = 1; k <= 16; k++) begin
      push(5'd2, 18'(k), 1);
      if (k == 15) chk("t4_not_full", full_out, 0);
      if (k == 15) chk("t4_no_ovf", ovf_out, 0);
    end
    chk("t4_full", full_out, 1);
    push(5'd2, 18'h3FFFF, 0);
    chk("t4_ovf", ovf_out, 1);
    chk("t4_full_hold", full_out, 1);
    rdy_in = 1'b1;
    drain("t4_drain");
    chk("t4_full_clr", full_out, 0);
    chk("t4_ovf_sticky", ovf_out, 1);
    cfg(STAT_CLR_ADDR, 0, 0);
    chk("t4_ovf_clr", ovf_out, 0);
    // disabling ch7 mid-word affects only the next word
    push(5'd2, 18'h03333, 1);
    cfg(CHAN_EN_ADDR, 7, 0);
    push(5'd2, 18'h04444, 1);
    drain("t5_drain");
    cfg(CHAN_EN_ADDR, 7, 1);
    // reset mid fan-out
    push(5'd2, 18'h05555, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_dv", dv_out, 0);
    chk("t6_rst_chan", chan_out, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_full", full_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("t6_idle_dv", dv_out, 0);
    end
    cfg(CHAN_SRC_SEL_ADDR, 3, 2);
    cfg(CHAN_EN_ADDR, 3, 1);
    push(5'd2, 18'h06666, 1);
    @(negedge clk_in);
    chk("t6_new_dv", dv_out, 1);
    chk("t6_new_chan", chan_out, 3);
    drain("t6_drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
